// File: rtl/lcd_driver_if.sv
// Host-side request handshake for the HD44780 write sequencer: four ASCII
// bytes or one command byte, a request strobe and an idle/ready flag.
interface lcd_driver_if;
  logic [31:0] data;
  logic        selectCD;
  logic        enableWriting;
  logic        LCD_Available;

  modport master (output data, selectCD, enableWriting, input LCD_Available);
  modport slave  (input data, selectCD, enableWriting, output LCD_Available);
endinterface

// File: rtl/lcd_driver.sv
// HD44780 8-bit parallel driver: power-up wait, fixed init sequence, then
// command or 4-character writes, each byte followed by a busy-flag poll.
module lcd_driver #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned EN_CYCLES      = 12
) (
  input  logic        clk,
  input  logic        rst,
  lcd_driver_if.slave req,
  inout  wire  [7:0]  LCD_DATA,
  output logic        LCD_RW,
  output logic        LCD_RS,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        LCD_BLON
);

  localparam int unsigned CNT_MAX = (POWERUP_CYCLES > EN_CYCLES) ? POWERUP_CYCLES : EN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYCLES - 1);

  typedef enum logic [3:0] {
    PWR_WAIT, W_SETUP, W_EN, W_HOLD, BF_SETUP, BF_EN, BF_HOLD, NEXT, IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic             cd_q, cd_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic [7:0]       byte_q, byte_d;
  logic             en_q, en_d, rw_q, rw_d, rs_q, rs_d, avail_q, avail_d;
  logic             phase_end;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] char_at(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      cd_q        <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      byte_q      <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      rs_q        <= 1'b0;
      avail_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      cd_q        <= cd_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      byte_q      <= byte_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      rs_q        <= rs_d;
      avail_q     <= avail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    cd_d        = cd_q;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    byte_d      = byte_q;
    phase_end   = (cnt_q == EN_LAST);

    case (state_q)
      PWR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          idx_d   = 2'd0;
          byte_d  = init_cmd(2'd0);
          state_d = W_SETUP;
        end
      end
      W_SETUP, W_EN, W_HOLD, BF_SETUP, BF_EN, BF_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (phase_end) begin
          cnt_d = '0;
          case (state_q)
            W_SETUP:  state_d = W_EN;
            W_EN:     state_d = W_HOLD;
            W_HOLD:   state_d = BF_SETUP;
            BF_SETUP: state_d = BF_EN;
            BF_EN: begin
              busy_d  = LCD_DATA[7];
              state_d = BF_HOLD;
            end
            default:  state_d = busy_q ? BF_SETUP : NEXT;
          endcase
        end
      end
      NEXT: begin
        state_d = IDLE;
        if (!init_done_q) begin
          if (idx_q == 2'd3) begin
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            byte_d  = init_cmd(idx_q + 2'd1);
            state_d = W_SETUP;
          end
        end else if (cd_q && idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          byte_d  = char_at(data_q, idx_q + 2'd1);
          state_d = W_SETUP;
        end
      end
      IDLE: begin
        if (req.enableWriting) begin
          data_d  = req.data;
          cd_d    = req.selectCD;
          idx_d   = 2'd0;
          cnt_d   = '0;
          byte_d  = req.selectCD ? req.data[31:24] : req.data[7:0];
          state_d = W_SETUP;
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    // Pin outputs are registered from the next state so they change cleanly with it.
    en_d    = (state_d == W_EN) || (state_d == BF_EN);
    rw_d    = state_d inside {BF_SETUP, BF_EN, BF_HOLD};
    rs_d    = (state_d inside {W_SETUP, W_EN, W_HOLD}) && init_done_d && cd_d;
    avail_d = (state_d == IDLE) && init_done_d;
  end

  assign LCD_DATA          = LCD_RW ? 8'hzz : byte_q;
  assign LCD_EN            = en_q;
  assign LCD_RW            = rw_q;
  assign LCD_RS            = rs_q;
  assign LCD_ON            = 1'b1;
  assign LCD_BLON          = 1'b1;
  assign req.LCD_Available = avail_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: phase-timeline model compared every cycle, plus
// literal byte-log checks for init, character, command, busy and reset cases.
module tb_lcd_driver;
  localparam int P = 5;
  localparam int E = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_driver_if req_if();
  wire  [7:0] lcd_data;
  logic       lcd_rw, lcd_rs, lcd_en, lcd_on, lcd_blon;

  lcd_driver #(.POWERUP_CYCLES(P), .EN_CYCLES(E)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req_if),
    .LCD_DATA (lcd_data),
    .LCD_RW   (lcd_rw),
    .LCD_RS   (lcd_rs),
    .LCD_EN   (lcd_en),
    .LCD_ON   (lcd_on),
    .LCD_BLON (lcd_blon)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Panel side: status reads as busy for 3 cycles of the read, longer if busy_extra polls requested.
  logic [7:0] tb_bus = 8'h00;
  int busy_extra = 0;
  int rw_cyc = 0;
  assign lcd_data = lcd_rw ? tb_bus : 8'hzz;
  always @(posedge clk) begin
    #1;
    if (lcd_rw) rw_cyc++;
    else rw_cyc = 0;
    tb_bus = (lcd_rw && rw_cyc <= 3 + 3 * E * busy_extra) ? 8'h80 : 8'h00;
  end

  // Expected per-cycle pin values; bus_mode 0 = unchecked, 1 = written byte, 2 = released (panel value).
  typedef struct packed {
    logic en, rw, rs, avail;
    logic [1:0] bus_mode;
    logic [7:0] bus;
  } exp_t;

  exp_t exp_q[$];
  logic m_idle = 1'b0;
  logic need_init = 1'b1;

  function automatic void push_n(input int n, input exp_t e);
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endfunction

  function automatic void push_byte(input logic rs, input logic [7:0] b, input int polls);
    exp_t w;
    exp_t r;
    w = '{en: 1'b0, rw: 1'b0, rs: rs, avail: 1'b0, bus_mode: 2'd1, bus: b};
    push_n(E, w); w.en = 1'b1; push_n(E, w); w.en = 1'b0; push_n(E, w);
    for (int k = 0; k < polls; k++) begin
      r = '{en: 1'b0, rw: 1'b1, rs: 1'b0, avail: 1'b0, bus_mode: 2'd2, bus: 8'h00};
      push_n(E, r); r.en = 1'b1; push_n(E, r); r.en = 1'b0; push_n(E, r);
    end
    push_n(1, '{en: 1'b0, rw: 1'b0, rs: 1'b0, avail: 1'b0, bus_mode: 2'd0, bus: 8'h00});
  endfunction

  always @(posedge clk) begin
    logic [31:0] init_seq;
    init_seq = 32'h380C0106;
    if (rst) begin
      exp_q.delete();
      need_init = 1'b1;
      m_idle    = 1'b0;
    end else if (need_init) begin
      need_init = 1'b0;
      push_n(P - 1, '{en: 1'b0, rw: 1'b0, rs: 1'b0, avail: 1'b0, bus_mode: 2'd0, bus: 8'h00});
      for (int i = 0; i < 4; i++) push_byte(1'b0, init_seq[31 - 8 * i -: 8], busy_extra + 1);
    end else if (m_idle && req_if.enableWriting) begin
      m_idle = 1'b0;
      if (req_if.selectCD)
        for (int i = 0; i < 4; i++) push_byte(1'b1, req_if.data[31 - 8 * i -: 8], busy_extra + 1);
      else
        push_byte(1'b0, req_if.data[7:0], busy_extra + 1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic have;
    have = 1'b1;
    if (rst) e = '{en: 1'b0, rw: 1'b0, rs: 1'b0, avail: 1'b0, bus_mode: 2'd1, bus: 8'h00};
    else if (exp_q.size() > 0) e = exp_q.pop_front();
    else if (!need_init) begin
      e = '{en: 1'b0, rw: 1'b0, rs: 1'b0, avail: 1'b1, bus_mode: 2'd0, bus: 8'h00};
      m_idle = 1'b1;
    end else have = 1'b0;
    if (have) begin
      chk("LCD_EN", lcd_en, e.en);
      chk("LCD_RW", lcd_rw, e.rw);
      chk("LCD_RS", lcd_rs, e.rs);
      chk("LCD_Available", req_if.LCD_Available, e.avail);
      chk("LCD_ON", lcd_on, 1'b1);
      chk("LCD_BLON", lcd_blon, 1'b1);
      if (e.bus_mode == 2'd1) chk("LCD_DATA write", lcd_data, e.bus);
      if (e.bus_mode == 2'd2) chk("LCD_DATA released", lcd_data, tb_bus);
    end
  end

  // Log of strobed bytes and read strobes, for literal checks.
  logic [8:0] wr_log[$];
  int rd_pulses = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      if (!lcd_rw) wr_log.push_back({lcd_rs, lcd_data});
      else rd_pulses++;
    end
    prev_en = lcd_en;
  end

  task automatic check_log(input string name, input logic rs, input logic [63:0] bytes, input int n);
    chk({name, " byte count"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++)
      chk({name, " byte"}, {23'b0, wr_log[i]}, {23'b0, rs, bytes[63 - 8 * i -: 8]});
    wr_log.delete();
  endtask

  task automatic wait_avail(input logic lvl, input int budget, input string name);
    int c;
    c = 0;
    while (req_if.LCD_Available !== lvl && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (req_if.LCD_Available !== lvl) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout, LCD_Available=%b, expected %b", name, req_if.LCD_Available, lvl);
    end
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic cd);
    req_if.data          = d;
    req_if.selectCD      = cd;
    req_if.enableWriting = 1'b1;
    @(negedge clk);
    chk("accept drops LCD_Available", req_if.LCD_Available, 1'b0);
    #1;
    req_if.enableWriting = 1'b0;
  endtask

  initial begin
    int c;
    req_if.data          = 32'h0;
    req_if.selectCD      = 1'b0;
    req_if.enableWriting = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    wait_avail(1'b1, 400, "init done");
    check_log("init", 1'b0, 64'h380C0106_00000000, 4);
    chk("init read strobes", rd_pulses, 4);

    send(32'h48454C4C, 1'b1);
    wait_avail(1'b1, 400, "HELL done");
    check_log("HELL", 1'b1, 64'h48454C4C_00000000, 4);

    // Strobe held high: second word loaded at the next return to IDLE.
    req_if.data          = 32'h4F205749;
    req_if.selectCD      = 1'b1;
    req_if.enableWriting = 1'b1;
    wait_avail(1'b0, 10, "held accept 1");
    req_if.data = 32'h4C4C2120;
    wait_avail(1'b1, 400, "held idle 1");
    wait_avail(1'b0, 10, "held accept 2");
    req_if.enableWriting = 1'b0;
    wait_avail(1'b1, 400, "held done");
    check_log("O WI LL! ", 1'b1, 64'h4F205749_4C4C2120, 8);

    busy_extra = 2;
    rd_pulses  = 0;
    send(32'h00000001, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    req_if.data          = 32'h48454C4C;
    req_if.selectCD      = 1'b1;
    req_if.enableWriting = 1'b1;
    @(negedge clk);
    #1 req_if.enableWriting = 1'b0;
    wait_avail(1'b1, 400, "command done");
    check_log("command", 1'b0, 64'h01000000_00000000, 1);
    chk("busy read strobes", rd_pulses, 3);
    busy_extra = 0;

    send(32'h48454C4C, 1'b1);
    c = 0;
    while (wr_log.size() < 2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("reached byte 2", wr_log.size(), 2);
    #1 rst = 1'b1;
    #1;
    chk("rst LCD_EN", lcd_en, 1'b0);
    chk("rst LCD_RS", lcd_rs, 1'b0);
    chk("rst LCD_RW", lcd_rw, 1'b0);
    chk("rst LCD_Available", req_if.LCD_Available, 1'b0);
    chk("rst LCD_DATA", lcd_data, 8'h00);
    wr_log.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_avail(1'b1, 400, "reinit done");
    check_log("reinit", 1'b0, 64'h380C0106_00000000, 4);
    send(32'h48454C4C, 1'b1);
    wait_avail(1'b1, 400, "HELL resend done");
    check_log("HELL resend", 1'b1, 64'h48454C4C_00000000, 4);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
